// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP output path.
package msdap_pkg;
    localparam int MSDAP_OUT_W = 40;
    localparam int CNT_W       = 6;

    typedef logic [MSDAP_OUT_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } out_state_t;
endpackage

// File: rtl/msdap_out_chan.sv
// One output channel: hold register + valid flag, MSB-first shift register, overrun detect.
// Capture is unconditional (no backpressure); ovr_o pulses when an unconsumed word is replaced.
module msdap_out_chan
    import msdap_pkg::*;
#(
    parameter int DATA_W = MSDAP_OUT_W
) (
    input  logic              sClk,
    input  logic              reset,
    input  logic              start,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic              load_i,
    input  logic              shift_i,
    output logic              hv_o,
    output logic              msb_o,
    output logic              ovr_o
);
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              hv_q, hv_d;

    always_comb begin
        hold_d = hold_q;
        hv_d   = hv_q;
        sh_d   = sh_q;
        if (ready_i) begin
            hold_d = y_i;
            hv_d   = 1'b1;
        end else if (load_i) begin
            hv_d   = 1'b0;
        end
        // The zero fill leaves sh_q empty once a frame ends, so the pin idles low.
        if (load_i) begin
            sh_d = hold_q;
        end else if (shift_i) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge sClk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            hv_q   <= 1'b0;
            sh_q   <= '0;
        end else if (start) begin
            hold_q <= '0;
            hv_q   <= 1'b0;
            sh_q   <= '0;
        end else begin
            hold_q <= hold_d;
            hv_q   <= hv_d;
            sh_q   <= sh_d;
        end
    end

    assign hv_o  = hv_q;
    assign msb_o = sh_q[DATA_W-1];
    assign ovr_o = ready_i & hv_q & ~load_i;
endmodule

// File: rtl/msdap_out_serializer.sv
// Frames L/R ALU results onto serial pins; a frame starts one edge after both words are held.
// No backpressure: new words are always captured, and an unconsumed overwrite sets sticky overrun.
module msdap_out_serializer
    import msdap_pkg::*;
#(
    parameter int DATA_W = MSDAP_OUT_W
) (
    input  logic              sClk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] y_L,
    input  logic              ready_L,
    input  logic [DATA_W-1:0] y_R,
    input  logic              ready_R,
    output logic              OutReady,
    output logic              OutputL,
    output logic              OutputR,
    output logic              busy,
    output logic              overrun
);
    out_state_t       state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             out_rdy_q;
    logic             overrun_q;

    logic hv_l, hv_r, ovr_l, ovr_r;
    logic load, shift;

    // Reload on the last bit gives back-to-back frames with no idle cycle.
    assign load  = hv_l & hv_r & ((state_q != SHIFT) | (bit_cnt_q == '0));
    assign shift = (state_q == SHIFT) & ~load;

    msdap_out_chan #(.DATA_W(DATA_W)) u_chan_l (
        .sClk    (sClk),
        .reset   (reset),
        .start   (start),
        .ready_i (ready_L),
        .y_i     (y_L),
        .load_i  (load),
        .shift_i (shift),
        .hv_o    (hv_l),
        .msb_o   (OutputL),
        .ovr_o   (ovr_l)
    );

    msdap_out_chan #(.DATA_W(DATA_W)) u_chan_r (
        .sClk    (sClk),
        .reset   (reset),
        .start   (start),
        .ready_i (ready_R),
        .y_i     (y_R),
        .load_i  (load),
        .shift_i (shift),
        .hv_o    (hv_r),
        .msb_o   (OutputR),
        .ovr_o   (ovr_r)
    );

    always_ff @(posedge sClk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            out_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (start) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            out_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_q | ovr_l | ovr_r;
            if (load) begin
                state_q   <= SHIFT;
                bit_cnt_q <= CNT_W'(DATA_W - 1);
                out_rdy_q <= 1'b1;
            end else if ((state_q == SHIFT) && (bit_cnt_q != '0)) begin
                bit_cnt_q <= bit_cnt_q - CNT_W'(1);
            end else begin
                // Not loading, so hv flags next cycle are simply hv | ready.
                state_q   <= (hv_l | ready_L | hv_r | ready_R) ? WAIT : IDLE;
                bit_cnt_q <= '0;
                out_rdy_q <= 1'b0;
            end
        end
    end

    assign OutReady = out_rdy_q;
    assign busy     = (state_q == SHIFT);
    assign overrun  = overrun_q;
endmodule

// File: doc/msdap_out_serializer.md
# msdap_out_serializer

Output transmitter for the MSDAP datapath: captures the 40-bit results produced by the left and right ALU channels (each qualified by its one-cycle `prev_OutReady` pulse) and shifts them out bit-serially on `OutputL`/`OutputR`. `OutReady` frames each 40-bit word. The block sits between the two ALU instances and the chip's serial output pins. It is the sending end of the per-sample result hand-off that the ALU initiates.

## Interface
- `DATA_W`, default 40: result word width and serial frame length in sClk cycles.
- `sClk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `start`, input, 1: synchronous clear. Same effect as `reset`, but applied at the clock edge.
- `y_L`, input, DATA_W: left-channel result. Valid only in a cycle where `ready_L`=1.
- `ready_L`, input, 1: left result strobe. One-cycle pulse, driven from the ALU's `prev_OutReady`.
- `y_R`, input, DATA_W: right-channel result.
- `ready_R`, input, 1: right result strobe.
- `OutReady`, output, 1: high for exactly DATA_W consecutive cycles per frame.
- `OutputL`, output, 1: left serial data, MSB first.
- `OutputR`, output, 1: right serial data, MSB first.
- `busy`, output, 1: high in SHIFT state.
- `overrun`, output, 1: sticky. Set when a channel's hold register is overwritten before it has been consumed.

## Operation
- Each channel has two registers:
  - Hold register `hold_x` with a valid flag `hv_x`.
  - Shift register `sh_x`.
- Capture:
  - `ready_x`=1 at an edge loads `y_x` into `hold_x` and sets `hv_x`.
  - If `hv_x` was already set and is not being consumed at that same edge, `overrun` is set. The new word replaces the old one.
- FSM states:
  - IDLE: both `hv` flags clear.
  - WAIT: exactly one `hv` flag set.
  - SHIFT: frame in progress.
- Load condition: `hv_L && hv_R`, evaluated in IDLE/WAIT, or in SHIFT when `bit_cnt`==0. When it holds at an edge:
  - `sh_L`←`hold_L` and `sh_R`←`hold_R`.
  - `bit_cnt`←DATA_W-1.
  - State←SHIFT.
  - Both `hv` flags are cleared, except that a `ready_x` arriving at that same edge re-captures and keeps `hv_x`=1 with no overrun.
- In SHIFT:
  - `OutputL`=`sh_L[DATA_W-1]` and `OutputR`=`sh_R[DATA_W-1]`.
  - Each edge shifts left by 1, fills with 0, and decrements `bit_cnt`.
- At an edge with `bit_cnt`==0:
  - If the load condition holds, reload for a back-to-back frame with no gap.
  - Otherwise go to IDLE or WAIT according to the `hv` flags.
- Outside SHIFT: `OutputL`=`OutputR`=0 and `OutReady`=0.
- Channel arrival order and skew are arbitrary. A frame starts only when both channels are held.

## Timing
- Reset or `start` values:
  - `OutReady`=0, `OutputL`=0, `OutputR`=0, `busy`=0, `overrun`=0.
  - Both `hv` flags=0, all registers 0, state=IDLE.
- `start` during SHIFT aborts the frame. Outputs are 0 from the following cycle.
- Latency: the later of the two `ready` pulses is sampled at edge k. `hv` is set at edge k, load happens at edge k+1, and `OutReady`=1 with bit DATA_W-1 on the pins from edge k+1. Bit 0 is on the pins after edge k+DATA_W. `OutReady` falls at edge k+DATA_W+1 unless a reload occurs.
- `OutReady` is never high for fewer than DATA_W cycles. Consecutive frames with no gap give continuous high.
- Simultaneous `ready_L` and `ready_R` at edge k: frame starts at edge k+1.
- A `ready` arriving while shifting is captured and its frame follows the current one.
- `overrun` clears only on `reset` or `start`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `msdap_pkg` holds:
  - Typedef `out_state_t` {IDLE, WAIT, SHIFT}.
  - Constant `MSDAP_OUT_W`=40.
  - Typedef `word_t` = logic[MSDAP_OUT_W-1:0].
- Sub-module `msdap_out_chan`: hold register, `hv` flag, shift register and overrun detect for one channel. It is instantiated twice, for L and R.
- The top level holds the FSM and `bit_cnt` (6 bits).

## Test plan
- Drive `ready_L`,`ready_R` at the same edge with `y_L`=40'h8000000001 and `y_R`=40'h00000000FF. Required:
  - `OutReady` high for 40 cycles starting one edge later.
  - `OutputL` bits 1,0×38,1.
  - `OutputR` 32 zeros then 8 ones.
- Drive `ready_L` at cycle 0 and `ready_R` at cycle 5, with `y_L`=40'hAAAAAAAAAA and `y_R`=40'h5555555555. Required:
  - `OutReady` rises after cycle 6.
  - `OutputL`=1010…, `OutputR`=0101….
  - `busy` low during cycles 0-5.
- Assert new `ready_L`/`ready_R` during bit 20 of a frame. Required: second frame starts immediately after bit 0 of the first, giving 80 continuous `OutReady` cycles, with `overrun`=0.
- Pulse `ready_L` twice while `ready_R` is absent. Required: `overrun`=1, and the second `y_L` value is the one transmitted once `ready_R` arrives.
- Pulse `start` at bit 10 of a frame, then drive `reset`=0 asynchronously mid-frame. Required:
  - After `start`: outputs 0 and `OutReady`=0 at the next edge, with `overrun` cleared.
  - After `reset`: all outputs 0 immediately, without waiting for a clock edge.
